// File: rtl/tl_conflict_monitor.sv
// ---------------------------------------------------------------------------
// tl_conflict_monitor
//
// Receive-side safety monitor for the 12-bit four-way traffic-light bus.
// Bus layout: W[11:9] S[8:6] E[5:3] N[2:0]. Each field is one-hot:
// 001 = GREEN, 010 = YELLOW, 100 = RED.
//
// The monitor sits between the signal controller and the lamp drivers.
// It checks encoding, conflicts, colour sequence and dwell time, and passes
// the bus through one register stage. Any violation latches a fault. While
// the fault is latched, every lamp flashes red until the fault is cleared.
//
// Parameters
//   MIN_GREEN   minimum consecutive GREEN samples before a field may leave GREEN
//   MIN_YELLOW  minimum consecutive YELLOW samples before leaving YELLOW
//   FLASH_HALF  length of each flash half-period in clk cycles (>= 1)
//   MAX_HOLD    watchdog limit, in cycles of an unchanged bus
//
// Optional feature macro
//   TLM_WATCHDOG_EN  when defined, an unchanged bus held for MAX_HOLD cycles
//                    (outside emergency mode) latches fault code 5.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   tl_in       in   light bus from the controller
//   emg         in   emergency mode (N may jump to GREEN, others may drop to RED)
//   clr_fault   in   level request to clear a latched fault
//   lamp_out    out  registered lamp drive (flashing all-red while faulted)
//   fault       out  fault latched
//   fault_code  out  0 none, 1 encoding, 2 conflict, 3 illegal step,
//                    4 dwell, 5 watchdog
//   active_dir  out  direction that is not RED: 0 N, 1 E, 2 S, 3 W
//   dir_valid   out  exactly one direction is non-RED (qualifies active_dir)
// ---------------------------------------------------------------------------
module tl_conflict_monitor #(
  parameter int unsigned MIN_GREEN  = 1,
  parameter int unsigned MIN_YELLOW = 1,
  parameter int unsigned FLASH_HALF = 4,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] tl_in,
  input  logic        emg,
  input  logic        clr_fault,
  output logic [11:0] lamp_out,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [1:0]  active_dir,
  output logic        dir_valid
);

  localparam logic [2:0]  L_GREEN   = 3'b001;
  localparam logic [2:0]  L_YELLOW  = 3'b010;
  localparam logic [2:0]  L_RED     = 3'b100;
  localparam logic [11:0] L_ALL_RED = 12'h924;
  localparam logic [11:0] L_ALL_OFF = 12'h000;

  // Dwell thresholds are compared against the 8-bit run counters, so
  // values above 255 are not meaningful.
  localparam logic [7:0]  L_MIN_G      = 8'(MIN_GREEN);
  localparam logic [7:0]  L_MIN_Y      = 8'(MIN_YELLOW);
  localparam logic [15:0] L_FLASH_LAST = 16'(FLASH_HALF - 1);

  typedef enum logic {
    ST_NORMAL,
    ST_FAULT
  } state_t;

  state_t      r_state;
  logic [2:0]  r_code;
  logic [11:0] r_lamp;
  logic [1:0]  r_active_dir;
  logic        r_dir_valid;
  logic [11:0] r_prev;
  logic        r_prev_valid;
  logic [15:0] r_flash_cnt;
  logic        r_flash_off;
  logic [7:0]  r_cnt [4];

  logic [2:0]  w_cur [4];
  logic [2:0]  w_prv [4];
  logic [7:0]  w_cnt_next [4];
  logic [3:0]  w_field_bad;
  logic [3:0]  w_field_live;
  logic [3:0]  w_field_change;
  logic [3:0]  w_exempt;
  logic [3:0]  w_field_step;
  logic [3:0]  w_field_dwell;
  logic        w_conflict;
  logic        w_single;
  logic [1:0]  w_dir;
  logic        w_wd_trip;
  logic [2:0]  w_code;
  logic        w_clear;

  // Per-field decode of the current sample against the previous one.
  // In emergency mode N may jump straight to GREEN and the other three
  // may drop straight to RED; those steps skip both step and dwell checks.
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_field
      assign w_cur[g] = tl_in[3*g +: 3];
      assign w_prv[g] = r_prev[3*g +: 3];

      assign w_field_bad[g]    = !((w_cur[g] == L_GREEN) || (w_cur[g] == L_YELLOW) ||
                                   (w_cur[g] == L_RED));
      assign w_field_live[g]   = (w_cur[g] != L_RED);
      assign w_field_change[g] = (w_cur[g] != w_prv[g]);

      assign w_exempt[g] = emg && ((g == 0) ? (w_cur[g] == L_GREEN) : (w_cur[g] == L_RED));

      assign w_field_step[g] = r_prev_valid && !w_exempt[g] &&
                               (((w_prv[g] == L_GREEN)  && (w_cur[g] == L_RED))    ||
                                ((w_prv[g] == L_YELLOW) && (w_cur[g] == L_GREEN))  ||
                                ((w_prv[g] == L_RED)    && (w_cur[g] == L_YELLOW)));

      assign w_field_dwell[g] = r_prev_valid && !w_exempt[g] &&
                                (((w_prv[g] == L_GREEN)  && (w_cur[g] != L_GREEN)  &&
                                  (r_cnt[g] < L_MIN_G)) ||
                                 ((w_prv[g] == L_YELLOW) && (w_cur[g] != L_YELLOW) &&
                                  (r_cnt[g] < L_MIN_Y)));

      // Run counter: 1 on a colour change (or clear), otherwise saturating +1.
      assign w_cnt_next[g] = (w_clear || w_field_change[g]) ? 8'd1 :
                             (r_cnt[g] == 8'hFF)             ? 8'hFF :
                                                               r_cnt[g] + 8'd1;
    end
  endgenerate

  // More than one live field: clearing the lowest set bit leaves something.
  assign w_conflict = ((w_field_live & (w_field_live - 4'd1)) != 4'd0);
  assign w_single   = (w_field_live != 4'd0) && !w_conflict;

  // Index of the single live field; only meaningful when w_single is set.
  always_comb begin
    w_dir = 2'd0;
    case (w_field_live)
      4'b0010: w_dir = 2'd1;
      4'b0100: w_dir = 2'd2;
      4'b1000: w_dir = 2'd3;
      default: w_dir = 2'd0;
    endcase
  end

`ifdef TLM_WATCHDOG_EN
  localparam logic [16:0] L_MAX_HOLD = 17'(MAX_HOLD);

  logic [15:0] r_hold;
  logic        w_same;

  assign w_same = (tl_in == r_prev);

  // Trips on the held cycle that would bring the count up to MAX_HOLD.
  assign w_wd_trip = !emg && w_same && (({1'b0, r_hold} + 17'd1) >= L_MAX_HOLD);

  // Hold counter: reloads on clear or any bus change, freezes during an
  // emergency so a long emergency hold never trips it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= 16'd0;
    end else if (w_clear) begin
      r_hold <= 16'd0;
    end else if (emg) begin
      r_hold <= r_hold;
    end else if (!w_same) begin
      r_hold <= 16'd0;
    end else if (r_hold != 16'hFFFF) begin
      r_hold <= r_hold + 16'd1;
    end
  end
`else
  assign w_wd_trip = 1'b0;
`endif

  // Lowest-numbered violation wins when several occur together.
  always_comb begin
    w_code = 3'd0;
    if (|w_field_bad) begin
      w_code = 3'd1;
    end else if (w_conflict) begin
      w_code = 3'd2;
    end else if (|w_field_step) begin
      w_code = 3'd3;
    end else if (|w_field_dwell) begin
      w_code = 3'd4;
    end else if (w_wd_trip) begin
      w_code = 3'd5;
    end
  end

  // A clear is honoured only on a completely clean sample, so any fresh
  // violation in the same cycle keeps the fault latched.
  assign w_clear = (r_state == ST_FAULT) && clr_fault && (w_code == 3'd0);

  // Fault state machine with registered outputs. The flash phase counter
  // starts at the fault-raising edge with the lamps ON (all RED).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_NORMAL;
      r_code       <= 3'd0;
      r_lamp       <= L_ALL_RED;
      r_active_dir <= 2'd0;
      r_dir_valid  <= 1'b0;
      r_prev       <= L_ALL_RED;
      r_prev_valid <= 1'b0;
      r_flash_cnt  <= 16'd0;
      r_flash_off  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= 8'd0;
      end
    end else begin
      r_prev       <= tl_in;
      r_prev_valid <= !w_clear;
      r_active_dir <= w_dir;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end

      case (r_state)
        ST_NORMAL: begin
          if (w_code != 3'd0) begin
            r_state     <= ST_FAULT;
            r_code      <= w_code;
            r_lamp      <= L_ALL_RED;
            r_dir_valid <= 1'b0;
            r_flash_cnt <= 16'd0;
            r_flash_off <= 1'b0;
          end else begin
            r_lamp      <= tl_in;
            r_dir_valid <= w_single;
          end
        end

        ST_FAULT: begin
          if (w_clear) begin
            r_state     <= ST_NORMAL;
            r_code      <= 3'd0;
            r_lamp      <= tl_in;
            r_dir_valid <= w_single;
            r_flash_cnt <= 16'd0;
            r_flash_off <= 1'b0;
          end else begin
            r_dir_valid <= 1'b0;
            if (r_flash_cnt == L_FLASH_LAST) begin
              r_flash_cnt <= 16'd0;
              r_flash_off <= !r_flash_off;
              r_lamp      <= r_flash_off ? L_ALL_RED : L_ALL_OFF;
            end else begin
              r_flash_cnt <= r_flash_cnt + 16'd1;
              r_lamp      <= r_flash_off ? L_ALL_OFF : L_ALL_RED;
            end
          end
        end

        default: begin
          r_state <= ST_NORMAL;
        end
      endcase
    end
  end

  assign lamp_out   = r_lamp;
  assign fault      = (r_state == ST_FAULT);
  assign fault_code = r_code;
  assign active_dir = r_active_dir;
  assign dir_valid  = r_dir_valid;

endmodule

// File: tb/tb_tl_conflict_monitor.sv
// ---------------------------------------------------------------------------
// tb_tl_conflict_monitor
//
// Drives two monitors from one stimulus stream. dut0 uses the default
// parameters. dut1 uses MIN_GREEN=3, so that it can show dwell faults.
// A behavioural model predicts every output of both instances each cycle.
// Directed checks with literal expected values pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_tl_conflict_monitor;

`ifdef TLM_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam int FLASH = 4;
  localparam int HOLD  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] tlIn;
  logic        emg;
  logic        clrFault;

  logic [11:0] lampOut   [2];
  logic        faultOut  [2];
  logic [2:0]  codeOut   [2];
  logic [1:0]  dirOut    [2];
  logic        dirValOut [2];

  int checks = 0;
  int errors = 0;

  // Model state, one entry per instance.
  logic [11:0] mPrev      [2];
  bit          mPrevValid [2];
  int          mRun       [2][4];
  int          mHold      [2];
  bit          mFault     [2];
  int          mCode      [2];
  int          mFlashK    [2];
  logic [11:0] expLamp    [2];
  bit          expDirVal  [2];
  int          expDir     [2];

  always #5 clk = ~clk;

  tl_conflict_monitor #(.MIN_GREEN(1), .MIN_YELLOW(1), .FLASH_HALF(FLASH), .MAX_HOLD(HOLD)) dut0 (
    .clk(clk), .rst(rst), .tl_in(tlIn), .emg(emg), .clr_fault(clrFault),
    .lamp_out(lampOut[0]), .fault(faultOut[0]), .fault_code(codeOut[0]),
    .active_dir(dirOut[0]), .dir_valid(dirValOut[0])
  );

  tl_conflict_monitor #(.MIN_GREEN(3), .MIN_YELLOW(1), .FLASH_HALF(FLASH), .MAX_HOLD(HOLD)) dut1 (
    .clk(clk), .rst(rst), .tl_in(tlIn), .emg(emg), .clr_fault(clrFault),
    .lamp_out(lampOut[1]), .fault(faultOut[1]), .fault_code(codeOut[1]),
    .active_dir(dirOut[1]), .dir_valid(dirValOut[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] tl, input logic e, input logic c);
    tlIn     = tl;
    emg      = e;
    clrFault = c;
    @(posedge clk);
    #1;
  endtask

  // Force a known clean state: drive all-red once (which may itself raise a
  // fault), then repeat it with a clear request so nothing changes.
  task automatic clearFault();
    applyStimulus(12'h924, 1'b0, 1'b0);
    applyStimulus(12'h924, 1'b0, 1'b1);
  endtask

  function automatic int minGreenOf(input int j);
    return (j == 0) ? 1 : 3;
  endfunction

  function automatic int fieldOf(input logic [11:0] v, input int i);
    logic [2:0] f;
    f = v[3*i +: 3];
    return int'(f);
  endfunction

  task automatic resetModel();
    for (int j = 0; j < 2; j++) begin
      mPrev[j]      = 12'h924;
      mPrevValid[j] = 1'b0;
      mHold[j]      = 0;
      mFault[j]     = 1'b0;
      mCode[j]      = 0;
      mFlashK[j]    = 0;
      expLamp[j]    = 12'h924;
      expDirVal[j]  = 1'b0;
      expDir[j]     = 0;
      for (int i = 0; i < 4; i++) mRun[j][i] = 0;
    end
  endtask

  // Colour values: 1 GREEN, 2 YELLOW, 4 RED.
  task automatic stepModel(input int j);
    int c, p, code, liveCnt, liveIdx;
    bit badEnc, stepBad, dwellBad, exempt, same, wdTrip, clear;
    badEnc = 0; stepBad = 0; dwellBad = 0; liveCnt = 0; liveIdx = 0;
    for (int i = 0; i < 4; i++) begin
      c = fieldOf(tlIn, i);
      p = fieldOf(mPrev[j], i);
      if (!(c == 1 || c == 2 || c == 4)) badEnc = 1;
      if (c != 4) begin
        liveCnt++;
        liveIdx = i;
      end
      exempt = emg && ((i == 0) ? (c == 1) : (c == 4));
      if (mPrevValid[j] && !exempt) begin
        if ((p == 1 && c == 4) || (p == 2 && c == 1) || (p == 4 && c == 2)) stepBad = 1;
        if (p == 1 && c != 1 && mRun[j][i] < minGreenOf(j)) dwellBad = 1;
        if (p == 2 && c != 2 && mRun[j][i] < 1) dwellBad = 1;
      end
    end
    same   = (tlIn == mPrev[j]);
    wdTrip = WD_EN && !emg && same && (mHold[j] + 1 >= HOLD);
    code   = badEnc ? 1 : (liveCnt > 1) ? 2 : stepBad ? 3 : dwellBad ? 4 : wdTrip ? 5 : 0;
    clear  = mFault[j] && clrFault && (code == 0);

    for (int i = 0; i < 4; i++) begin
      if (clear || fieldOf(tlIn, i) != fieldOf(mPrev[j], i)) mRun[j][i] = 1;
      else if (mRun[j][i] < 255) mRun[j][i]++;
    end
    if (clear) mHold[j] = 0;
    else if (!emg) begin
      if (!same) mHold[j] = 0;
      else if (mHold[j] < 65535) mHold[j]++;
    end

    if (!mFault[j] && code != 0) begin
      mFault[j]  = 1;
      mCode[j]   = code;
      mFlashK[j] = 0;
    end else if (clear) begin
      mFault[j] = 0;
      mCode[j]  = 0;
    end else if (mFault[j]) begin
      mFlashK[j]++;
    end
    mPrevValid[j] = !clear;
    mPrev[j]      = tlIn;

    if (mFault[j]) begin
      expLamp[j]   = (((mFlashK[j] / FLASH) % 2) == 0) ? 12'h924 : 12'h000;
      expDirVal[j] = 1'b0;
    end else begin
      expLamp[j]   = tlIn;
      expDirVal[j] = (liveCnt == 1);
      expDir[j]    = liveIdx;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) resetModel();
    else begin
      stepModel(0);
      stepModel(1);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int j = 0; j < 2; j++) begin
        checkOutput($sformatf("model d%0d lamp", j), 32'(lampOut[j]), 32'(expLamp[j]));
        checkOutput($sformatf("model d%0d fault", j), 32'(faultOut[j]), 32'(mFault[j]));
        checkOutput($sformatf("model d%0d code", j), 32'(codeOut[j]), 32'(mCode[j]));
        checkOutput($sformatf("model d%0d dir_valid", j), 32'(dirValOut[j]), 32'(expDirVal[j]));
        if (expDirVal[j]) begin
          checkOutput($sformatf("model d%0d active_dir", j), 32'(dirOut[j]), 32'(expDir[j]));
        end
      end
    end
  end

  initial begin
    #400000;
    errors++;
    $display("[TB] FAIL timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  logic [11:0] legalSeq [8];
  int          legalDir [8];
  logic [11:0] flashExp [9];

  initial begin
    legalSeq = '{12'h921, 12'h922, 12'h90C, 12'h914, 12'h864, 12'h8A4, 12'h324, 12'h524};
    legalDir = '{0, 0, 1, 1, 2, 2, 3, 3};
    flashExp = '{12'h924, 12'h924, 12'h924, 12'h924, 12'h000, 12'h000, 12'h000, 12'h000, 12'h924};

    rst = 1'b1; tlIn = 12'h924; emg = 1'b0; clrFault = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset lamp", 32'(lampOut[0]), 32'h924);
    checkOutput("reset fault", 32'(faultOut[0]), 32'd0);
    checkOutput("reset code", 32'(codeOut[0]), 32'd0);
    checkOutput("reset dir", 32'(dirOut[0]), 32'd0);
    checkOutput("reset dir_valid", 32'(dirValOut[0]), 32'd0);
    rst = 1'b0;
    applyStimulus(12'h924, 1'b0, 1'b0);

    // Legal rotation, three rounds, one state per clock.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) begin
        applyStimulus(legalSeq[k], 1'b0, 1'b0);
        checkOutput("legal lamp", 32'(lampOut[0]), 32'(legalSeq[k]));
        checkOutput("legal dir", 32'(dirOut[0]), 32'(legalDir[k]));
        checkOutput("legal dir_valid", 32'(dirValOut[0]), 32'd1);
        checkOutput("legal fault", 32'(faultOut[0]), 32'd0);
      end
    end

    // Bad encoding, clear refused while still bad, then accepted.
    clearFault();
    applyStimulus(12'h921, 1'b0, 1'b0);
    checkOutput("enc pre fault", 32'(faultOut[0]), 32'd0);
    applyStimulus(12'h923, 1'b0, 1'b0);
    checkOutput("enc fault", 32'(faultOut[0]), 32'd1);
    checkOutput("enc code", 32'(codeOut[0]), 32'd1);
    checkOutput("enc lamp", 32'(lampOut[0]), 32'h924);
    applyStimulus(12'h923, 1'b0, 1'b1);
    checkOutput("enc clr refused", 32'(faultOut[0]), 32'd1);
    checkOutput("enc code held", 32'(codeOut[0]), 32'd1);
    applyStimulus(12'h921, 1'b0, 1'b1);
    checkOutput("enc cleared", 32'(faultOut[0]), 32'd0);
    checkOutput("enc cleared code", 32'(codeOut[0]), 32'd0);
    checkOutput("enc cleared lamp", 32'(lampOut[0]), 32'h921);
    // First sample after a clear has no step check (G->R here).
    applyStimulus(12'h924, 1'b0, 1'b0);
    checkOutput("post clear no step d0", 32'(faultOut[0]), 32'd0);
    checkOutput("post clear no step d1", 32'(faultOut[1]), 32'd0);

    // Illegal step E GREEN -> RED, then the same step legal in emergency.
    clearFault();
    applyStimulus(12'h90C, 1'b0, 1'b0);
    applyStimulus(12'h924, 1'b0, 1'b0);
    checkOutput("step fault", 32'(faultOut[0]), 32'd1);
    checkOutput("step code", 32'(codeOut[0]), 32'd3);
    clearFault();
    checkOutput("step cleared", 32'(faultOut[0]), 32'd0);
    applyStimulus(12'h90C, 1'b1, 1'b0);
    applyStimulus(12'h924, 1'b1, 1'b0);
    applyStimulus(12'h921, 1'b1, 1'b0);
    checkOutput("emg step d0", 32'(faultOut[0]), 32'd0);
    checkOutput("emg step d1", 32'(faultOut[1]), 32'd0);
    checkOutput("emg lamp", 32'(lampOut[0]), 32'h921);

    // Dwell on dut1 (MIN_GREEN=3), then conflict+illegal step on dut0.
    clearFault();
    applyStimulus(12'h921, 1'b0, 1'b0);
    applyStimulus(12'h921, 1'b0, 1'b0);
    applyStimulus(12'h922, 1'b0, 1'b0);
    checkOutput("dwell d1 fault", 32'(faultOut[1]), 32'd1);
    checkOutput("dwell d1 code", 32'(codeOut[1]), 32'd4);
    checkOutput("dwell d0 fault", 32'(faultOut[0]), 32'd0);
    applyStimulus(12'h909, 1'b0, 1'b0);
    checkOutput("conflict fault", 32'(faultOut[0]), 32'd1);
    checkOutput("conflict code", 32'(codeOut[0]), 32'd2);
    checkOutput("conflict dir_valid", 32'(dirValOut[0]), 32'd0);
    checkOutput("flash 1", 32'(lampOut[0]), 32'(flashExp[0]));
    for (int n = 1; n < 9; n++) begin
      applyStimulus(12'h909, 1'b0, 1'b0);
      checkOutput($sformatf("flash %0d", n + 1), 32'(lampOut[0]), 32'(flashExp[n]));
    end
    checkOutput("d1 code held", 32'(codeOut[1]), 32'd4);

    // Reset in the middle of a flash phase.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midflash rst lamp", 32'(lampOut[0]), 32'h924);
    checkOutput("midflash rst fault", 32'(faultOut[0]), 32'd0);
    checkOutput("midflash rst code", 32'(codeOut[0]), 32'd0);
    checkOutput("midflash rst d1 fault", 32'(faultOut[1]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Watchdog: hold N GREEN unchanged.
    clearFault();
    applyStimulus(12'h921, 1'b0, 1'b0);
    repeat (15) applyStimulus(12'h921, 1'b0, 1'b0);
    checkOutput("hold 15 fault", 32'(faultOut[0]), 32'd0);
    applyStimulus(12'h921, 1'b0, 1'b0);
    checkOutput("hold 16 fault", 32'(faultOut[0]), WD_EN ? 32'd1 : 32'd0);
    checkOutput("hold 16 code", 32'(codeOut[0]), WD_EN ? 32'd5 : 32'd0);

    // Same hold under emergency never trips.
    clearFault();
    checkOutput("hold cleared", 32'(faultOut[0]), 32'd0);
    repeat (20) applyStimulus(12'h921, 1'b1, 1'b0);
    checkOutput("emg hold fault", 32'(faultOut[0]), 32'd0);
    checkOutput("emg hold lamp", 32'(lampOut[0]), 32'h921);
    applyStimulus(12'h921, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
